// File: rtl/emu_pkg.sv
// emu_pkg: shared definitions for the emulation sequencer.
//   - emu_state_e : sequencer state encoding
//   - EMU_*_DEF   : default NUM_STIM / NUM_OUT / DUT_HOLD values
//   - EMU_ADDR_W  : width of the wrapper byte index (Addr_emu)
//   - last_idx()  : index of the final byte in an n-byte transfer
package emu_pkg;

  localparam int EMU_ADDR_W       = 3;
  localparam int EMU_NUM_STIM_DEF = 3;
  localparam int EMU_NUM_OUT_DEF  = 3;
  localparam int EMU_DUT_HOLD_DEF = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WRITE,
    ST_LOAD,
    ST_CLK_HI,
    ST_CLK_LO,
    ST_GET,
    ST_RD_ADDR,
    ST_RD_CAP,
    ST_RD_SEND
  } emu_state_e;

  function automatic logic [EMU_ADDR_W-1:0] last_idx(input int n);
    return EMU_ADDR_W'(n - 1);
  endfunction

endpackage

// File: rtl/emu_clk_gen.sv
// emu_clk_gen: generates one DUT clock period from clk_emu.
// After a start pulse, clk_dut is high for DUT_HOLD cycles, then low for
// DUT_HOLD cycles. The phase timer is a down-counter reloaded at each phase.
// Ports:
//   clk_emu, rst_emu_n : clock, async active-low reset
//   start              : begin a DUT clock period (sampled on clk_emu)
//   phase_end          : current phase is in its final cycle
//   done               : final cycle of the low phase (period complete)
//   clk_dut            : registered DUT clock
module emu_clk_gen
  import emu_pkg::*;
#(
  parameter int DUT_HOLD = EMU_DUT_HOLD_DEF
) (
  input  logic clk_emu,
  input  logic rst_emu_n,
  input  logic start,
  output logic phase_end,
  output logic done,
  output logic clk_dut
);

  localparam int            CW       = $clog2(DUT_HOLD + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DUT_HOLD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          hi_q, hi_d;
  logic          clk_dut_q, clk_dut_d;

  assign phase_end = active_q && (cnt_q == '0);
  assign done      = phase_end && !hi_q;
  assign clk_dut   = clk_dut_q;

  always_comb begin
    cnt_d     = cnt_q;
    active_d  = active_q;
    hi_d      = hi_q;
    clk_dut_d = clk_dut_q;
    if (start) begin
      active_d  = 1'b1;
      hi_d      = 1'b1;
      cnt_d     = CNT_LOAD;
      clk_dut_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        if (hi_q) begin
          hi_d      = 1'b0;
          cnt_d     = CNT_LOAD;
          clk_dut_d = 1'b0;
        end else begin
          active_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_emu or negedge rst_emu_n) begin
    if (!rst_emu_n) begin
      cnt_q     <= '0;
      active_q  <= 1'b0;
      hi_q      <= 1'b0;
      clk_dut_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      hi_q      <= hi_d;
      clk_dut_q <= clk_dut_d;
    end
  end

endmodule

// File: rtl/emu_sequencer.sv
// emu_sequencer: host-driven cycle sequencer for an emulated DUT.
// Collects NUM_STIM stimulus bytes from the host, writes them to the
// emulation wrapper, loads them, runs one DUT clock period, captures the
// outputs and streams NUM_OUT result bytes back to the host.
// Ports:
//   clk_emu, rst_emu_n          : clock, async active-low reset
//   s_data/s_valid/s_ready      : host stimulus stream
//   m_data/m_valid/m_ready      : host result stream
//   Din_emu/Addr_emu            : byte and index presented to the wrapper
//   load_emu/get_emu            : wrapper latch / capture strobes
//   clk_dut                     : generated DUT clock
//   Dout_emu                    : wrapper readback (one cycle after Addr_emu)
//   busy                        : sequencer not idle
//   cycle_cnt                   : completed DUT clock periods
// Build option: define EMU_SEQ_CYCLE_CNT_EN to implement cycle_cnt;
// otherwise the port reads 0 and no counter exists.
//
// state      | meaning
// -----------+------------------------------------------------------
// IDLE       | waiting for the first stimulus byte
// WRITE      | accepting stimulus bytes, each written to the wrapper
// LOAD       | load_emu strobe, stimulus latched into the DUT
// CLK_HI     | clk_dut high for DUT_HOLD cycles
// CLK_LO     | clk_dut low for DUT_HOLD cycles
// GET        | get_emu strobe, DUT outputs captured by the wrapper
// RD_ADDR    | present output index to the wrapper
// RD_CAP     | sample wrapper readback into m_data
// RD_SEND    | offer m_data to the host until m_ready
module emu_sequencer
  import emu_pkg::*;
#(
  parameter int NUM_STIM = EMU_NUM_STIM_DEF,
  parameter int NUM_OUT  = EMU_NUM_OUT_DEF,
  parameter int DUT_HOLD = EMU_DUT_HOLD_DEF
) (
  input  logic                  clk_emu,
  input  logic                  rst_emu_n,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [7:0]            Din_emu,
  output logic [EMU_ADDR_W-1:0] Addr_emu,
  output logic                  load_emu,
  output logic                  get_emu,
  output logic                  clk_dut,
  input  logic [7:0]            Dout_emu,
  output logic                  busy,
  output logic [15:0]           cycle_cnt
);

  localparam logic [EMU_ADDR_W-1:0] STIM_LAST = last_idx(NUM_STIM);
  localparam logic [EMU_ADDR_W-1:0] OUT_LAST  = last_idx(NUM_OUT);

  emu_state_e            state_q, state_d;
  logic [EMU_ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]            din_emu_q, din_emu_d;
  logic [EMU_ADDR_W-1:0] addr_emu_q, addr_emu_d;
  logic [7:0]            m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  s_ready_q, s_ready_d;
  logic                  load_emu_q, load_emu_d;
  logic                  get_emu_q, get_emu_d;
  logic                  busy_q, busy_d;

  logic clk_start;
  logic clk_phase_end;
  logic clk_done;

  emu_clk_gen #(
    .DUT_HOLD (DUT_HOLD)
  ) u_clk_gen (
    .clk_emu   (clk_emu),
    .rst_emu_n (rst_emu_n),
    .start     (clk_start),
    .phase_end (clk_phase_end),
    .done      (clk_done),
    .clk_dut   (clk_dut)
  );

  assign clk_start = (state_q == ST_LOAD);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    din_emu_d  = din_emu_q;
    addr_emu_d = addr_emu_q;
    m_data_d   = m_data_q;
    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          state_d = ST_WRITE;
          idx_d   = '0;
        end
      end
      ST_WRITE: begin
        if (s_valid && s_ready_q) begin
          din_emu_d  = s_data;
          addr_emu_d = idx_q;
          if (idx_q == STIM_LAST) begin
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + EMU_ADDR_W'(1);
          end
        end
      end
      ST_LOAD:   state_d = ST_CLK_HI;
      ST_CLK_HI: if (clk_phase_end) state_d = ST_CLK_LO;
      ST_CLK_LO: if (clk_done) state_d = ST_GET;
      ST_GET: begin
        // first readback index is presented on entry to RD_ADDR
        state_d    = ST_RD_ADDR;
        idx_d      = '0;
        addr_emu_d = '0;
      end
      ST_RD_ADDR: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        m_data_d = Dout_emu;
        state_d  = ST_RD_SEND;
      end
      ST_RD_SEND: begin
        if (m_valid_q && m_ready) begin
          if (idx_q == OUT_LAST) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d      = idx_q + EMU_ADDR_W'(1);
            addr_emu_d = idx_q + EMU_ADDR_W'(1);
            state_d    = ST_RD_ADDR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    s_ready_d  = (state_d == ST_WRITE);
    busy_d     = (state_d != ST_IDLE);
    load_emu_d = (state_d == ST_LOAD);
    get_emu_d  = (state_d == ST_GET);
    // first RD_SEND cycle lets m_data settle; valid from the second cycle on
    m_valid_d  = (state_q == ST_RD_SEND) && (state_d == ST_RD_SEND);
  end

  always_ff @(posedge clk_emu or negedge rst_emu_n) begin
    if (!rst_emu_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      din_emu_q  <= '0;
      addr_emu_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      s_ready_q  <= 1'b0;
      load_emu_q <= 1'b0;
      get_emu_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      din_emu_q  <= din_emu_d;
      addr_emu_q <= addr_emu_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      s_ready_q  <= s_ready_d;
      load_emu_q <= load_emu_d;
      get_emu_q  <= get_emu_d;
      busy_q     <= busy_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign Din_emu  = din_emu_q;
  assign Addr_emu = addr_emu_q;
  assign load_emu = load_emu_q;
  assign get_emu  = get_emu_q;
  assign busy     = busy_q;

`ifdef EMU_SEQ_CYCLE_CNT_EN
  logic [15:0] cycle_cnt_q, cycle_cnt_d;

  // counts a period when the low phase completes; wraps naturally at 16 bits
  assign cycle_cnt_d = (state_q == ST_CLK_LO && clk_done) ? cycle_cnt_q + 16'd1
                                                          : cycle_cnt_q;

  always_ff @(posedge clk_emu or negedge rst_emu_n) begin
    if (!rst_emu_n) cycle_cnt_q <= '0;
    else            cycle_cnt_q <= cycle_cnt_d;
  end

  assign cycle_cnt = cycle_cnt_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_emu_sequencer.sv
module tb_emu_sequencer;

  localparam int HOLD    = 2;
  localparam int LATENCY = 1 + 2 * HOLD + 1 + 3;

  logic        clk_emu = 1'b0;
  logic        rst_emu_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  Din_emu;
  logic [2:0]  Addr_emu;
  logic        load_emu;
  logic        get_emu;
  logic        clk_dut;
  logic [7:0]  Dout_emu = 8'h00;
  logic        busy;
  logic [15:0] cycle_cnt;

  emu_sequencer #(
    .NUM_STIM (3),
    .NUM_OUT  (3),
    .DUT_HOLD (HOLD)
  ) dut (
    .clk_emu   (clk_emu),
    .rst_emu_n (rst_emu_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .Din_emu   (Din_emu),
    .Addr_emu  (Addr_emu),
    .load_emu  (load_emu),
    .get_emu   (get_emu),
    .clk_dut   (clk_dut),
    .Dout_emu  (Dout_emu),
    .busy      (busy),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk_emu = ~clk_emu;

  int cyc = 0;
  always @(posedge clk_emu) cyc <= cyc + 1;

  // behavioral wrapper readback: registered lookup of the presented index
  logic [7:0] dout_mem [8];
  always @(posedge clk_emu) Dout_emu <= dout_mem[Addr_emu];

  // strobe / DUT clock observer
  int   load_cnt, get_cnt, both_cnt, hi_cnt, load_cyc, get_cyc, rise_cyc;
  logic clk_prev = 1'b0;
  always @(negedge clk_emu) begin
    if (load_emu) begin load_cnt++; load_cyc = cyc; end
    if (get_emu)  begin get_cnt++;  get_cyc  = cyc; end
    if (load_emu && get_emu) both_cnt++;
    if (clk_dut) hi_cnt++;
    if (clk_dut && !clk_prev) rise_cyc = cyc;
    clk_prev = clk_dut;
  end

  typedef struct {
    logic [2:0][7:0] stim;
    logic [2:0][7:0] dout;
    logic [2:0][7:0] exp;
    int              gap1;
    int              stall_idx;
    int              stall_n;
  } vec_t;

  vec_t        vt [4];
  logic [7:0]  exp_q [$];
  logic [15:0] exp_cc = 16'h0000;
  int          acc_cyc;
  int          nvec = 0;
  int          nbad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ctl"}, {s_ready, m_valid, load_emu, get_emu, clk_dut, busy}, 0);
    check({tag, " m_data"}, m_data, 0);
    check({tag, " din/addr"}, {Din_emu, Addr_emu}, 0);
    check({tag, " cycle_cnt"}, cycle_cnt, 0);
  endtask

  task automatic send(input vec_t v);
    bit ok;
    for (int i = 0; i < 3; i++) begin
      if (i == 1 && v.gap1 > 0) begin
        s_valid = 1'b0;
        for (int g = 0; g < v.gap1; g++) begin
          s_data = 8'($urandom);
          @(posedge clk_emu); #1;
        end
        check("gap hold", {Din_emu, Addr_emu}, {v.stim[0], 3'd0});
      end
      s_valid = 1'b1;
      s_data  = v.stim[i];
      ok = 1'b0;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk_emu);
        if (s_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        check("accept timeout", 0, 1);
        s_valid = 1'b0;
        return;
      end
      acc_cyc = cyc + 1;
      @(posedge clk_emu); #1;
      check("write", {Din_emu, Addr_emu}, {v.stim[i], 3'(i)});
    end
    s_valid = 1'b0;
    s_data  = 8'($urandom);
    check("s_ready after last", s_ready, 0);
  endtask

  task automatic recv(input vec_t v);
    bit         ok;
    logic [7:0] e;
    for (int j = 0; j < 3; j++) begin
      m_ready = !(v.stall_n > 0 && v.stall_idx == j);
      ok = 1'b0;
      for (int t = 0; t < 60; t++) begin
        @(negedge clk_emu);
        if (m_valid) begin ok = 1'b1; break; end
      end
      if (!ok || exp_q.size() == 0) begin
        check("m_valid timeout", 0, 1);
        m_ready = 1'b1;
        return;
      end
      if (j == 0) check("latency", cyc - acc_cyc, LATENCY);
      if (!m_ready) begin
        for (int k = 0; k < v.stall_n; k++) begin
          check("stall hold", {m_valid, m_data}, {1'b1, exp_q[0]});
          if (k == v.stall_n - 1) begin
            @(posedge clk_emu); #1;
            m_ready = 1'b1;
          end
          @(negedge clk_emu);
        end
      end
      e = exp_q.pop_front();
      check("m_data", {m_valid, m_data}, {1'b1, e});
      @(posedge clk_emu); #1;
      @(negedge clk_emu);
      check("m_valid drop", m_valid, 0);
    end
    check("idle after read", busy, 0);
    m_ready = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    for (int i = 0; i < 3; i++) begin
      dout_mem[i] = v.dout[i];
      exp_q.push_back(v.exp[i]);
    end
    load_cnt = 0; get_cnt = 0; both_cnt = 0; hi_cnt = 0;
    load_cyc = 0; get_cyc = 0; rise_cyc = 0;
    send(v);
    recv(v);
`ifdef EMU_SEQ_CYCLE_CNT_EN
    exp_cc = exp_cc + 16'd1;
`endif
    check("load pulses", load_cnt, 1);
    check("get pulses", get_cnt, 1);
    check("load&get overlap", both_cnt, 0);
    check("clk_dut high cycles", hi_cnt, HOLD);
    check("clk rise after load", rise_cyc - load_cyc, 1);
    check("get after load", get_cyc - load_cyc, 1 + 2 * HOLD);
    check("cycle_cnt", cycle_cnt, exp_cc);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    bit ok;
    for (int i = 0; i < 8; i++) dout_mem[i] = 8'h00;

    vt[0].stim = {8'h33, 8'h22, 8'h11}; vt[0].dout = {8'hC3, 8'h5A, 8'hA5};
    vt[0].exp  = {8'hC3, 8'h5A, 8'hA5}; vt[0].gap1 = 0; vt[0].stall_idx = 0; vt[0].stall_n = 0;
    vt[1].stim = {8'h33, 8'h22, 8'h11}; vt[1].dout = {8'hC3, 8'h5A, 8'hA5};
    vt[1].exp  = {8'hC3, 8'h5A, 8'hA5}; vt[1].gap1 = 0; vt[1].stall_idx = 1; vt[1].stall_n = 5;
    vt[2].stim = {8'h80, 8'hFF, 8'h00}; vt[2].dout = {8'h7F, 8'hFE, 8'h01};
    vt[2].exp  = {8'h7F, 8'hFE, 8'h01}; vt[2].gap1 = 0; vt[2].stall_idx = 0; vt[2].stall_n = 0;
    vt[3].stim = {8'hBE, 8'hAD, 8'hDE}; vt[3].dout = {8'h3C, 8'hFF, 8'h00};
    vt[3].exp  = {8'h3C, 8'hFF, 8'h00}; vt[3].gap1 = 3; vt[3].stall_idx = 0; vt[3].stall_n = 2;

    rst_emu_n = 1'b0;
    s_valid   = 1'b0;
    s_data    = 8'h00;
    m_ready   = 1'b1;
    repeat (3) @(posedge clk_emu);
    #1;
    check_reset_vals("reset");
    rst_emu_n = 1'b1;
    @(posedge clk_emu); #1;

    for (int v = 0; v < 4; v++) begin
      run_vec(vt[v]);
      repeat (2) @(posedge clk_emu);
      #1;
    end

    // reset pulsed while clk_dut is high
    for (int i = 0; i < 3; i++) dout_mem[i] = vt[0].dout[i];
    send(vt[0]);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk_emu);
      if (clk_dut) begin ok = 1'b1; break; end
    end
    check("reach CLK_HI", ok, 1);
    rst_emu_n = 1'b0;
    #1;
    check_reset_vals("mid reset");
    exp_cc = 16'h0000;
    #2;
    rst_emu_n = 1'b1;
    @(posedge clk_emu); #1;
    check("idle after reset", {busy, clk_dut}, 0);
    run_vec(vt[2]);
    repeat (2) @(posedge clk_emu);
    #1;

    // counter wrap
`ifdef EMU_SEQ_CYCLE_CNT_EN
    dut.cycle_cnt_q = 16'hFFFF;
    exp_cc = 16'hFFFF;
`endif
    run_vec(vt[0]);
    check("cycle_cnt after wrap run", cycle_cnt, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/emu_sequencer.md
EMU_SEQUENCER -- requirements
Module: emu_sequencer

Interface
REQ-001 Parameter NUM_STIM, default 3: stimulus bytes per DUT cycle; legal range 1..8.
REQ-002 Parameter NUM_OUT, default 3: captured output bytes per DUT cycle; legal range 1..8.
REQ-003 Parameter DUT_HOLD, default 2: clk_emu cycles per clk_dut phase (high, then low); legal range >=1.
REQ-004 clk_emu  in  1  sole clock; all logic on rising edge.
REQ-005 rst_emu_n  in  1  asynchronous, active-low reset.
REQ-006 s_data  in  8  host stimulus byte.
REQ-007 s_valid  in  1 / s_ready  out  1  host-side input handshake.
REQ-008 m_data  out  8  captured output byte to host.
REQ-009 m_valid  out  1 / m_ready  in  1  host-side output handshake.
REQ-010 Din_emu  out  8 / Addr_emu  out  3  byte and index presented to the downstream emulation wrapper.
REQ-011 load_emu  out  1 / get_emu  out  1  wrapper strobes: latch stimulus into the DUT / capture DUT outputs.
REQ-012 clk_dut  out  1  registered DUT clock, generated from clk_emu.
REQ-013 Dout_emu  in  8  wrapper readback byte; valid one clk_emu cycle after Addr_emu changes.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 cycle_cnt  out  16  count of completed DUT clock periods.

Function
REQ-016 States: IDLE, WRITE, LOAD, CLK_HI, CLK_LO, GET, RD_ADDR, RD_CAP, RD_SEND.
REQ-017 IDLE->WRITE when s_valid=1; index cleared to 0.
REQ-018 WRITE: s_ready=1; each accepted byte registers Din_emu<=s_data and Addr_emu<=index, then index increments; gaps in s_valid stall without side effects.
REQ-019 After byte NUM_STIM-1 is accepted, go to LOAD; load_emu SHALL be high for exactly one cycle, starting the cycle after the last write is presented.
REQ-020 CLK_HI: clk_dut=1 for DUT_HOLD cycles; CLK_LO: clk_dut=0 for DUT_HOLD cycles; cycle_cnt increments by 1 on leaving CLK_LO and wraps from 0xFFFF to 0.
REQ-021 GET: get_emu=1 for exactly one cycle; load_emu and get_emu are never high in the same cycle.
REQ-022 Per output index i: RD_ADDR drives Addr_emu=i; RD_CAP samples Dout_emu into m_data; RD_SEND holds m_valid=1 and m_data stable until m_ready=1.
REQ-023 After byte NUM_OUT-1 is transferred, go to IDLE.
REQ-024 s_ready=0 in every state except WRITE; m_valid=0 in every state except RD_SEND.
REQ-025 load_emu and get_emu are low during WRITE, so every write is taken by the wrapper.
REQ-026 Latency from the last stimulus acceptance to the first m_valid = 1 + 2*DUT_HOLD + 1 + 3 cycles.

Reset
REQ-027 Reset asserted at any time, including mid-sequence, SHALL force IDLE and clear the index.
REQ-028 Output values under reset: s_ready=0, m_valid=0, m_data=0, Din_emu=0, Addr_emu=0, load_emu=0, get_emu=0, clk_dut=0, busy=0, cycle_cnt=0.
REQ-029 After reset, no partial stimulus is retained; the host SHALL resend all NUM_STIM bytes.

Configuration
REQ-030 Macro EMU_SEQ_CYCLE_CNT_EN defined: cycle_cnt implemented per REQ-020.
REQ-031 Macro EMU_SEQ_CYCLE_CNT_EN undefined: the cycle_cnt port remains and is tied to 0; no counter flops exist.

Structure
REQ-032 Package emu_pkg SHALL hold the state encoding, the default NUM_STIM/NUM_OUT/DUT_HOLD values, and the 3-bit address width.
REQ-033 One sub-module, emu_clk_gen, SHALL implement the DUT_HOLD phase counter and the clk_dut flop, with a start input and a done output.

Verification
REQ-034 Bench drives 0x11,0x22,0x33 with continuous s_valid -> writes (Addr 0,0x11), (1,0x22), (2,0x33); one load pulse; clk_dut high for 2 then low for 2 cycles; one get pulse.
REQ-035 Behavioral wrapper model returns 0xA5,0x5A,0xC3 -> m_data sequence 0xA5,0x5A,0xC3; first m_valid 9 cycles after the last accept.
REQ-036 m_ready held low for 5 cycles on byte 1 -> m_valid stays 1 and m_data stays 0x5A throughout; no byte is lost or duplicated.
REQ-037 rst_emu_n pulsed low during CLK_HI -> clk_dut=0 immediately and state returns to IDLE; the next full sequence completes normally.
REQ-038 Preload cycle_cnt=0xFFFF, run one sequence -> cycle_cnt=0x0000 with the macro defined; cycle_cnt constant 0 when the macro is undefined.
